branch_redirect_ctrl: RTL
=========================

# branch_redirect_ctrl

Sequences control-flow redirects for the pipelined RV32I hart. It consumes the branch unit's 2-bit next-PC select and the resolved target in EX, flushes the wrong-path IF/ID and ID/EX slots, and holds a registered redirect request on a valid/ready handshake until fetch accepts it. It also issues the post-reset boot redirect, raises a trap on a misaligned target, and keeps saturating control-flow statistics counters.

## Interface
- RESET_ADDR, 32'h0000_0000: PC issued as the boot redirect after reset.
- CNT_W, 32: width of each statistics counter.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, synchronous and active-low.
- i_ex_valid  in  1  EX slot holds a valid instruction.
- i_ex_ctrl  in  1  EX instruction is jal, jalr or a conditional branch.
- i_ex_sel  in  2  branch unit select: 2'b11 = PC+4 (not taken); any other value = take the target.
- i_ex_target  in  32  resolved target (ALU result).
- i_redir_ready  in  1  fetch accepts the redirect this cycle.
- i_trap_ack  in  1  trap handler has taken the trap.
- o_redir_valid  out  1  redirect request pending.
- o_redir_pc  out  32  redirect PC; stable while o_redir_valid is high.
- o_flush_if_id  out  1  kill the IF/ID slot this cycle.
- o_flush_id_ex  out  1  kill the ID/EX slot this cycle.
- o_fetch_hold  out  1  fetch must not advance the PC sequentially.
- o_trap  out  1  misaligned-target trap pending.
- o_trap_pc  out  32  offending target.
- o_ctrl_cnt  out  CNT_W  retired control-flow instructions.
- o_taken_cnt  out  CNT_W  taken control-flow instructions.

## Operation
- Taken event: i_ex_valid & i_ex_ctrl & (i_ex_sel != 2'b11).
- Redirect is legal only when i_ex_target[1:0] == 2'b00. Otherwise the event is a trap.
- State BOOT (entered on reset):
  - o_redir_valid = 1, o_redir_pc = RESET_ADDR, o_fetch_hold = 1.
  - On i_redir_ready, go to IDLE.
- State IDLE:
  - o_redir_valid = 0, o_fetch_hold = 0.
  - On a taken event with an aligned target: o_flush_if_id and o_flush_id_ex go high in the same cycle (combinational). The target is registered into the redirect register, and the state goes to REDIR.
  - On a taken event with a misaligned target: both flushes go high, the target is registered into o_trap_pc, and the state goes to TRAP.
  - A not-taken control instruction causes no action apart from the counter update.
- State REDIR:
  - o_redir_valid = 1 and o_fetch_hold = 1.
  - Both flushes stay high every cycle, killing wrong-path slots.
  - EX events are ignored; they are wrong-path and not counted.
  - On i_redir_ready, go to IDLE. In that acceptance cycle, the flushes are still high.
- State TRAP:
  - o_trap = 1, o_fetch_hold = 1, both flushes high.
  - EX events are ignored.
  - On i_trap_ack, go to IDLE. The handler performs its own redirect.
- Counters:
  - In IDLE only, o_ctrl_cnt increments on i_ex_valid & i_ex_ctrl.
  - In IDLE only, o_taken_cnt increments on each taken event, including trapping ones.
  - Both counters saturate at all-ones and never wrap.
  - Both counters clear only on reset.

## Timing
- Reset (i_rst_n low at an edge):
  - state = BOOT, o_redir_pc = RESET_ADDR, o_trap_pc = 0, counters = 0.
  - o_trap = 0, flushes = 0, o_redir_valid = 1 from the first cycle after reset.
  - A reset in any state, including mid-REDIR or mid-TRAP, drops the pending request. No partial redirect is visible afterwards.
- Flush latency: 0 cycles from the taken event in cycle T.
- o_redir_valid latency: high from T+1, and held until the cycle in which i_redir_ready is sampled high.
- o_redir_pc must not change while o_redir_valid is high.
- Minimum redirect occupancy is 1 cycle (i_redir_ready already high at T+1). The earliest next accepted event is in cycle T+2.
- Back-to-back taken events in T and T+1: the T+1 event is wrong-path and ignored. Only the target from T is redirected.
- If i_trap_ack and a taken event coincide in TRAP, the event is ignored.

## Test plan
- Boot sequencing:
  - Release reset with i_redir_ready low for 3 cycles, then high.
  - Expect o_redir_valid high for 4 cycles with o_redir_pc = RESET_ADDR, then IDLE.
- Taken branch:
  - With beq, i_ex_sel = 2'b10 and i_ex_target = 32'h0000_0040.
  - Expect both flushes in T, and o_redir_valid with o_redir_pc = 0x40 at T+1.
  - With ready at T+1, expect IDLE at T+2; o_taken_cnt = 1 and o_ctrl_cnt = 1.
- Not taken and non-control:
  - Drive i_ex_sel = 2'b11 with i_ex_ctrl = 1: expect no flush and no redirect; o_ctrl_cnt increments and o_taken_cnt does not.
  - Drive i_ex_ctrl = 0: expect no counter change.
- Backpressure plus wrong-path:
  - Take jalr to 0x100, hold ready low for 5 cycles, and present a taken event to 0x200 during REDIR.
  - Expect o_redir_pc = 0x100 held throughout, flushes high every cycle, and counters unchanged by the second event.
- Misaligned target:
  - Take jal to 0x102.
  - Expect o_trap with o_trap_pc = 0x102, no o_redir_valid, and hold until i_trap_ack, then IDLE.
- Reset mid-REDIR and counter saturation:
  - Assert i_rst_n low during REDIR: expect BOOT with RESET_ADDR next cycle and counters cleared.
  - With CNT_W = 4, apply 20 taken events: expect o_taken_cnt stuck at 4'hF.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: sequences control-flow redirects for the RV32I hart.
// The boot redirect, taken-branch redirects and misaligned-target traps all go
// through one small FSM. Redirect/trap outputs are registered. The flushes are
// combinational, so the wrong-path slots die in the same cycle as the taken event.
module branch_redirect_ctrl #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ex_valid,
  input  logic             i_ex_ctrl,
  input  logic [1:0]       i_ex_sel,
  input  logic [31:0]      i_ex_target,
  input  logic             i_redir_ready,
  input  logic             i_trap_ack,
  output logic             o_redir_valid,
  output logic [31:0]      o_redir_pc,
  output logic             o_flush_if_id,
  output logic             o_flush_id_ex,
  output logic             o_fetch_hold,
  output logic             o_trap,
  output logic [31:0]      o_trap_pc,
  output logic [CNT_W-1:0] o_ctrl_cnt,
  output logic [CNT_W-1:0] o_taken_cnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    IDLE  = 2'd1,
    REDIR = 2'd2,
    TRAP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state_reg;
  logic        redir_valid_reg;
  logic        fetch_hold_reg;
  logic        trap_reg;
  logic [31:0] redir_pc_reg;
  logic [31:0] trap_pc_reg;
  logic        flush;

  logic ctrl_ev;
  logic taken_ev;
  logic aligned;
  logic in_idle;

  assign ctrl_ev  = i_ex_valid & i_ex_ctrl;
  assign taken_ev = ctrl_ev & (i_ex_sel != 2'b11);
  assign aligned  = (i_ex_target[1:0] == 2'b00);
  assign in_idle  = (state_reg == IDLE);

  // Flush wrong-path slots: on a taken event in IDLE, and for the whole
  // time a redirect or trap is outstanding.
  always_comb begin
    flush = 1'b0;
    case (state_reg)
      IDLE:        flush = taken_ev;
      REDIR, TRAP: flush = 1'b1;
      default:     flush = 1'b0;
    endcase
  end

  // Redirect/trap FSM. The outputs are registered alongside the state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg       <= BOOT;
      redir_valid_reg <= 1'b1;
      fetch_hold_reg  <= 1'b1;
      trap_reg        <= 1'b0;
      redir_pc_reg    <= RESET_ADDR;
      trap_pc_reg     <= 32'h0000_0000;
    end else begin
      case (state_reg)
        BOOT: begin
          if (i_redir_ready) begin
            state_reg       <= IDLE;
            redir_valid_reg <= 1'b0;
            fetch_hold_reg  <= 1'b0;
          end
        end
        IDLE: begin
          if (taken_ev) begin
            fetch_hold_reg <= 1'b1;
            if (aligned) begin
              state_reg       <= REDIR;
              redir_pc_reg    <= i_ex_target;
              redir_valid_reg <= 1'b1;
            end else begin
              state_reg   <= TRAP;
              trap_pc_reg <= i_ex_target;
              trap_reg    <= 1'b1;
            end
          end
        end
        REDIR: begin
          if (i_redir_ready) begin
            state_reg       <= IDLE;
            redir_valid_reg <= 1'b0;
            fetch_hold_reg  <= 1'b0;
          end
        end
        TRAP: begin
          if (i_trap_ack) begin
            state_reg      <= IDLE;
            trap_reg       <= 1'b0;
            fetch_hold_reg <= 1'b0;
          end
        end
        default: begin
          state_reg       <= IDLE;
          redir_valid_reg <= 1'b0;
          fetch_hold_reg  <= 1'b0;
          trap_reg        <= 1'b0;
        end
      endcase
    end
  end

  // Statistics counters: [0] control-flow, [1] taken. They count only in IDLE,
  // so wrong-path events are excluded. They saturate at all-ones.
  logic [CNT_W-1:0] cnt_reg [2];
  logic [1:0]       cnt_inc;

  assign cnt_inc = {in_idle & taken_ev, in_idle & ctrl_ev};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      // Saturating increment of one statistics counter.
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_inc[gi] && (cnt_reg[gi] != CNT_MAX)) begin
          cnt_reg[gi] <= cnt_reg[gi] + CNT_ONE;
        end
      end
    end
  endgenerate

  assign o_redir_valid = redir_valid_reg;
  assign o_redir_pc    = redir_pc_reg;
  assign o_flush_if_id = flush;
  assign o_flush_id_ex = flush;
  assign o_fetch_hold  = fetch_hold_reg;
  assign o_trap        = trap_reg;
  assign o_trap_pc     = trap_pc_reg;
  assign o_ctrl_cnt    = cnt_reg[0];
  assign o_taken_cnt   = cnt_reg[1];

endmodule
